hit_miss_checker: RTL and testbench
===================================

HIT_MISS_CHECKER -- requirements
Module: hit_miss_checker

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, `AXI_ADDR_WIDTH (64), request address width.
REQ-002 SHALL have parameter ID_WIDTH, `AXI_ID_WIDTH (16), transaction ID width.
REQ-003 SHALL have parameter DATA_WIDTH, `AXI_DATA_WIDTH (32), tag-word width; DATA_WIDTH = TAG_WIDTH+2.
REQ-004 SHALL have parameter INDEX_WIDTH, `INDEX_WIDTH (4), set-index bits, which are addr[INDEX_WIDTH-1:0].
REQ-005 SHALL have parameter TAG_WIDTH, 30, tag bits, which are addr[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH].
REQ-006 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- fifo_empty_i  in  1  request FIFO empty.
- fifo_read_en_o  out  1  pop request FIFO.
- fifo_data_i  in  ADDR_WIDTH+ID_WIDTH+1  {rw(1=write), id, addr}; valid the cycle after the pop.
- rid_i  in  ID_WIDTH  tag-response ID.
- rdata_i  in  DATA_WIDTH  {valid, dirty, tag}.
- rvalid_i  in  1  tag response valid.
- rready_o  out  1  tag response accepted.
- res_valid_o  out  1  lookup result valid.
- res_ready_i  in  1  result consumed.
- res_hit_o, res_rw_o, res_evict_o  out  1 each  hit; request rw; miss on a valid, dirty line.
- res_id_o  out  ID_WIDTH  request ID.
- res_addr_o  out  ADDR_WIDTH  request address.
- res_victim_tag_o  out  TAG_WIDTH  stored tag.
- id_err_o  out  1  sticky ID-mismatch flag.

Function
REQ-007 SHALL implement the FSM S_IDLE, S_POP, S_TAG, S_RESP, with at most one request in flight.
REQ-008 In S_IDLE with !fifo_empty_i, the block SHALL drive fifo_read_en_o=1 (combinational, for one cycle) and go to S_POP; otherwise it SHALL stay in S_IDLE.
REQ-009 S_POP SHALL register fifo_data_i into the rw, id and addr request registers, then go to S_TAG.
REQ-010 S_TAG SHALL drive rready_o=1; on rvalid_i it SHALL register rdata_i, compute the result and go to S_RESP. rready_o SHALL be 0 in every other state, so an early response is held by the sender.
REQ-011 Result computation: hit = rdata_i[DATA_WIDTH-1] AND (rdata_i[TAG_WIDTH-1:0] == the request tag field); evict = !hit AND valid AND rdata_i[DATA_WIDTH-2].
REQ-012 If rid_i != the request id on the accepting cycle, id_err_o SHALL set and stay set until reset; the lookup SHALL still complete.
REQ-013 S_RESP SHALL drive res_valid_o=1 and hold all res_* outputs stable until res_ready_i, then go to S_IDLE.
REQ-014 The minimum period SHALL be 4 cycles per request (S_IDLE to S_IDLE); no pop SHALL occur outside S_IDLE.
REQ-015 Tag responses SHALL be consumed in FIFO order, one response per popped entry.
REQ-016 All res_* outputs SHALL be registered; res_valid_o SHALL be decoded from the state register.

Reset
REQ-017 Asserting rst SHALL immediately force S_IDLE, clear all registers and drive every output to 0, including id_err_o and the counters.
REQ-018 Reset during S_POP, S_TAG or S_RESP SHALL silently drop the in-flight request; no result SHALL be produced after release.
REQ-019 The first pop after release SHALL occur no earlier than the first clock edge with rst low.

Configuration
REQ-020 With HIT_MISS_STAT_EN defined, the block SHALL add outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], each incremented on entry to S_RESP according to hit and saturating at 0xFFFF_FFFF.
REQ-021 Without HIT_MISS_STAT_EN, those ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-022 Read hit: FIFO entry {0,0x0007,0x0000_0000_0000_1235}, response rid=0x0007, rdata=0x8000_0123 -> res_hit=1, evict=0, res_id=0x0007, res_valid 4 cycles after the pop.
REQ-023 Dirty write miss: entry {1,0x0003,0x...0040}, rdata=0xC000_0055 -> hit=0, evict=1, res_rw=1, victim_tag=0x55.
REQ-024 Backpressure: hold res_ready_i=0 for 10 cycles -> outputs stable, no fifo_read_en_o, rready_o=0 throughout; res_ready_i=1 -> next pop in the following S_IDLE cycle.
REQ-025 ID mismatch: request id 0x0001, rid_i 0x0002 -> id_err_o=1 from the next cycle and persists; result still delivered.
REQ-026 Reset in S_TAG: pulse rst with rvalid_i high -> rready_o=0, res_valid_o never asserts, FIFO not re-popped until not empty.
REQ-027 Counters (macro on): 3 hits and 2 misses -> hit_cnt_o=3, miss_cnt_o=2; preload miss counter at 0xFFFF_FFFF plus one miss -> stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/hit_miss_checker.sv
// Cache tag lookup: pops one request, compares the returned tag word, reports hit / miss / dirty-evict (HIT_MISS_STAT_EN adds hit/miss counters).
// Latency: result valid on the third edge after the pop cycle; minimum 4 cycles per request, one request in flight.
// Backpressure: result held until res_ready_i; no pop and rready_o low while a request is outstanding.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 16
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 4
`endif

module hit_miss_checker #(
  parameter int ADDR_WIDTH  = `AXI_ADDR_WIDTH,
  parameter int ID_WIDTH    = `AXI_ID_WIDTH,
  parameter int DATA_WIDTH  = `AXI_DATA_WIDTH,
  parameter int INDEX_WIDTH = `INDEX_WIDTH,
  parameter int TAG_WIDTH   = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_empty_i,
  output logic                         fifo_read_en_o,
  input  logic [ADDR_WIDTH+ID_WIDTH:0] fifo_data_i,
  input  logic [ID_WIDTH-1:0]          rid_i,
  input  logic [DATA_WIDTH-1:0]        rdata_i,
  input  logic                         rvalid_i,
  output logic                         rready_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic                         res_hit_o,
  output logic                         res_rw_o,
  output logic                         res_evict_o,
  output logic [ID_WIDTH-1:0]          res_id_o,
  output logic [ADDR_WIDTH-1:0]        res_addr_o,
  output logic [TAG_WIDTH-1:0]         res_victim_tag_o,
  output logic                         id_err_o
`ifdef HIT_MISS_STAT_EN
  ,
  output logic [31:0]                  hit_cnt_o,
  output logic [31:0]                  miss_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_TAG, S_RESP} state_t;

  typedef struct packed {
    logic                  rw;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
  } req_t;

  state_t               state_q, state_d;
  req_t                 req_q;
  logic                 accept;
  logic                 line_valid, line_dirty, hit_w;
  logic [TAG_WIDTH-1:0] stored_tag, req_tag;

  assign line_valid = rdata_i[DATA_WIDTH-1];
  assign line_dirty = rdata_i[DATA_WIDTH-2];
  assign stored_tag = rdata_i[TAG_WIDTH-1:0];
  assign req_tag    = req_q.addr[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH];
  assign hit_w      = line_valid && (stored_tag == req_tag);

  always_comb begin
    state_d        = state_q;
    fifo_read_en_o = 1'b0;
    rready_o       = 1'b0;
    accept         = 1'b0;
    case (state_q)
      S_IDLE: begin
        // gated by rst so the pop strobe is low for the whole reset pulse
        if (!fifo_empty_i) begin
          fifo_read_en_o = !rst;
          state_d        = S_POP;
        end
      end
      S_POP:  state_d = S_TAG;
      S_TAG: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          accept  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      req_q            <= '0;
      res_hit_o        <= 1'b0;
      res_evict_o      <= 1'b0;
      res_victim_tag_o <= '0;
      id_err_o         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_POP) req_q <= fifo_data_i;
      if (accept) begin
        res_hit_o        <= hit_w;
        res_evict_o      <= !hit_w && line_valid && line_dirty;
        res_victim_tag_o <= stored_tag;
        if (rid_i != req_q.id) id_err_o <= 1'b1;
      end
    end
  end

  assign res_valid_o = (state_q == S_RESP);
  assign res_rw_o    = req_q.rw;
  assign res_id_o    = req_q.id;
  assign res_addr_o  = req_q.addr;

`ifdef HIT_MISS_STAT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit_w) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_hit_miss_checker.sv
// Directed bench for hit_miss_checker: a software request FIFO and tag responder feed the DUT,
// and a transaction-level model predicts every result, id error and counter value.
module tb_hit_miss_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty_i;
  logic        fifo_read_en_o;
  logic [80:0] fifo_data_i;
  logic [15:0] rid_i;
  logic [31:0] rdata_i;
  logic        rvalid_i;
  logic        rready_o;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        res_hit_o, res_rw_o, res_evict_o;
  logic [15:0] res_id_o;
  logic [63:0] res_addr_o;
  logic [29:0] res_victim_tag_o;
  logic        id_err_o;
`ifdef HIT_MISS_STAT_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  hit_miss_checker dut (
    .clk(clk), .rst(rst),
    .fifo_empty_i(fifo_empty_i), .fifo_read_en_o(fifo_read_en_o), .fifo_data_i(fifo_data_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_hit_o(res_hit_o), .res_rw_o(res_rw_o), .res_evict_o(res_evict_o),
    .res_id_o(res_id_o), .res_addr_o(res_addr_o), .res_victim_tag_o(res_victim_tag_o),
    .id_err_o(id_err_o)
`ifdef HIT_MISS_STAT_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [15:0] id;
    logic [63:0] addr;
    logic        hit;
    logic        evict;
    logic [29:0] vtag;
  } want_t;

  want_t       want_q[$];
  logic [80:0] fifo_q[$];
  logic [47:0] rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        in_flight = 1'b0;
  logic        want_id_err = 1'b0;
  logic [31:0] model_hits = 32'd0;
  logic [31:0] model_misses = 32'd0;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Tag = address bits above the 4 index bits, truncated to 30 bits; line word = {valid, dirty, tag}.
  function automatic want_t model(input logic rw, input logic [15:0] id, input logic [63:0] addr,
                                  input logic [31:0] rdata);
    want_t       w;
    logic [63:0] tag, stored;
    logic        v, d;
    tag     = (addr / 64'd16) % 64'h4000_0000;
    stored  = {32'd0, rdata} % 64'h4000_0000;
    v       = rdata >= 32'h8000_0000;
    d       = (rdata % 32'h8000_0000) >= 32'h4000_0000;
    w.rw    = rw;
    w.id    = id;
    w.addr  = addr;
    w.hit   = v && (tag == stored);
    w.evict = !w.hit && v && d;
    w.vtag  = stored[29:0];
    return w;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic txn(input logic rw, input logic [15:0] id, input logic [63:0] addr,
                     input logic [15:0] rid, input logic [31:0] rdata);
    fifo_q.push_back({rw, id, addr});
    rsp_q.push_back({rid, rdata});
    want_q.push_back(model(rw, id, addr, rdata));
  endtask

  task automatic wait_res(input string name);
    int n = 0;
    @(negedge clk);
    while (!res_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, res_valid_o, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((want_q.size() != 0 || in_flight) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 200, 1'b1);
    @(negedge clk);
  endtask

  // Request FIFO: data for a pop appears in the cycle after the pop strobe.
  initial begin : fifo_side
    logic popped;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;
    forever begin
      @(negedge clk);
      popped = !rst && fifo_read_en_o;
      @(posedge clk);
      #2;
      if (popped && fifo_q.size() != 0) fifo_data_i = fifo_q.pop_front();
      fifo_empty_i = (fifo_q.size() == 0);
    end
  end

  // Tag responder: offers the oldest response and holds it until accepted.
  initial begin : tag_side
    logic took;
    rvalid_i = 1'b0;
    rid_i    = '0;
    rdata_i  = '0;
    forever begin
      @(negedge clk);
      took = !rst && rvalid_i && rready_o;
      @(posedge clk);
      #2;
      if (took && rsp_q.size() != 0) void'(rsp_q.pop_front());
      if (rsp_q.size() != 0) begin
        rvalid_i         = 1'b1;
        {rid_i, rdata_i} = rsp_q[0];
      end else begin
        rvalid_i = 1'b0;
      end
    end
  end

  initial begin : compare
    want_t w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fifo_read_en_o) begin
          chk("pop_while_busy", in_flight, 1'b0);
          chk("pop_while_empty", fifo_empty_i, 1'b0);
        end
        if (rready_o) chk("rready_without_request", in_flight, 1'b1);
        chk("id_err", id_err_o, want_id_err);
        if (res_valid_o) begin
          if (want_q.size() == 0) begin
            chk("spurious_res", res_valid_o, 1'b0);
          end else begin
            w = want_q[0];
            chk("res_hit", res_hit_o, w.hit);
            chk("res_evict", res_evict_o, w.evict);
            chk("res_rw", res_rw_o, w.rw);
            chkw("res_id", 64'(res_id_o), 64'(w.id));
            chkw("res_addr", res_addr_o, w.addr);
            chkw("res_victim_tag", 64'(res_victim_tag_o), 64'(w.vtag));
          end
        end
        if (rready_o && rvalid_i && want_q.size() != 0 && rid_i != want_q[0].id) want_id_err = 1'b1;
        if (fifo_read_en_o) in_flight = 1'b1;
        if (res_valid_o && res_ready_i && want_q.size() != 0) begin
          if (want_q[0].hit) model_hits = sat_inc(model_hits);
          else model_misses = sat_inc(model_misses);
          void'(want_q.pop_front());
          in_flight = 1'b0;
        end
      end
    end
  end

  initial begin : main
    int n;
    rst         = 1'b1;
    res_ready_i = 1'b1;
    // read hit: tag 0x123 of address 0x1235 matches a valid clean line
    txn(1'b0, 16'h0007, 64'h0000_0000_0000_1235, 16'h0007, 32'h8000_0123);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pop", fifo_read_en_o, 1'b0);
    chk("rst_rready", rready_o, 1'b0);
    chk("rst_res_valid", res_valid_o, 1'b0);
    chk("rst_res_hit", res_hit_o, 1'b0);
    chk("rst_res_evict", res_evict_o, 1'b0);
    chk("rst_res_rw", res_rw_o, 1'b0);
    chkw("rst_res_id", 64'(res_id_o), 64'd0);
    chkw("rst_res_addr", res_addr_o, 64'd0);
    chkw("rst_res_victim", 64'(res_victim_tag_o), 64'd0);
    chk("rst_id_err", id_err_o, 1'b0);
`ifdef HIT_MISS_STAT_EN
    chkw("rst_hit_cnt", 64'(hit_cnt_o), 64'd0);
    chkw("rst_miss_cnt", 64'(miss_cnt_o), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("first_pop_after_rst", fifo_read_en_o, 1'b1);
    // the pop cycle counts as the first of four; res_valid shows in the fourth
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("latency_c%0d", k + 1), res_valid_o, k == 3);
    end
    chk("t1_hit", res_hit_o, 1'b1);
    chk("t1_evict", res_evict_o, 1'b0);
    chkw("t1_id", 64'(res_id_o), 64'h0007);
    chkw("t1_addr", res_addr_o, 64'h1235);
    chkw("t1_victim", 64'(res_victim_tag_o), 64'h123);
    wait_idle("t1_done");

    // dirty write miss: tag 0x4 against a valid dirty line holding 0x55
    txn(1'b1, 16'h0003, 64'h0000_0000_0000_0040, 16'h0003, 32'hC000_0055);
    wait_res("t2_res");
    chk("t2_hit", res_hit_o, 1'b0);
    chk("t2_evict", res_evict_o, 1'b1);
    chk("t2_rw", res_rw_o, 1'b1);
    chkw("t2_victim", 64'(res_victim_tag_o), 64'h55);
    wait_idle("t2_done");

    // back-to-back boundary patterns, checked by the model
    txn(1'b0, 16'h00A0, 64'hFFFF_0000_0000_0015, 16'h00A0, 32'h8000_0001);
    txn(1'b1, 16'h00A1, 64'h0000_0003_FFFF_FFF0, 16'h00A1, 32'hBFFF_FFFF);
    txn(1'b0, 16'h00A2, 64'h0000_0000_0000_0050, 16'h00A2, 32'h4000_0005);
    txn(1'b0, 16'h00A3, 64'h0000_0000_0000_0060, 16'h00A3, 32'h8000_0007);
    txn(1'b1, 16'hFFFF, 64'h0000_0000_0000_0128, 16'hFFFF, 32'hC000_0012);
    wait_idle("burst_done");

    // result backpressure with a second request waiting
    @(posedge clk);
    #1;
    res_ready_i = 1'b0;
    txn(1'b0, 16'h0010, 64'h0000_0000_0000_0200, 16'h0010, 32'h8000_0020);
    txn(1'b1, 16'h0011, 64'h0000_0000_0000_0300, 16'h0011, 32'hC000_0001);
    wait_res("bp_res");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_no_pop", fifo_read_en_o, 1'b0);
      chk("bp_no_rready", rready_o, 1'b0);
      chk("bp_valid_held", res_valid_o, 1'b1);
    end
    @(posedge clk);
    #1;
    res_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_pop", fifo_read_en_o, 1'b1);
    wait_idle("bp_done");

    // id mismatch: request id 1 answered with rid 2
    txn(1'b0, 16'h0001, 64'h0000_0000_0000_0400, 16'h0002, 32'h8000_0040);
    n = 0;
    @(negedge clk);
    while (!(rready_o && rvalid_i) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("id_accept_reached", rready_o && rvalid_i, 1'b1);
    chk("id_err_before", id_err_o, 1'b0);
    @(negedge clk);
    chk("id_err_set", id_err_o, 1'b1);
    chk("id_err_result", res_valid_o, 1'b1);
    wait_idle("id_done");
    txn(1'b0, 16'h0005, 64'h0000_0000_0000_0500, 16'h0005, 32'h0000_0050);
    wait_idle("id_clean_done");
    chk("id_err_sticky", id_err_o, 1'b1);

`ifdef HIT_MISS_STAT_EN
    chkw("hit_cnt", 64'(hit_cnt_o), 64'(model_hits));
    chkw("miss_cnt", 64'(miss_cnt_o), 64'(model_misses));
    chkw("hit_cnt_literal", 64'(hit_cnt_o), 64'd6);
    chkw("miss_cnt_literal", 64'(miss_cnt_o), 64'd5);
    @(posedge clk);
    #1;
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.miss_cnt_q;
    model_misses = 32'hFFFF_FFFF;
    txn(1'b0, 16'h000C, 64'h0000_0000_0000_0900, 16'h000C, 32'h0000_0000);
    wait_idle("sat_done");
    chkw("miss_cnt_sat", 64'(miss_cnt_o), 64'hFFFF_FFFF);
    chkw("hit_cnt_after_sat", 64'(hit_cnt_o), 64'(model_hits));
`endif

    // reset while the lookup sits in S_TAG with a response offered
    txn(1'b0, 16'h0009, 64'h0000_0000_0000_0700, 16'h0009, 32'h8000_0070);
    n = 0;
    @(negedge clk);
    while (!rready_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("rst_tag_reached", rready_o, 1'b1);
    chk("rst_tag_rvalid", rvalid_i, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_tag_rready", rready_o, 1'b0);
    chk("rst_tag_valid", res_valid_o, 1'b0);
    chk("rst_tag_id_err", id_err_o, 1'b0);
`ifdef HIT_MISS_STAT_EN
    chkw("rst_tag_hit_cnt", 64'(hit_cnt_o), 64'd0);
`endif
    @(posedge clk);
    #1;
    want_q.delete();
    rsp_q.delete();
    in_flight    = 1'b0;
    want_id_err  = 1'b0;
    model_hits   = 32'd0;
    model_misses = 32'd0;
    rst          = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst_drop_no_result", res_valid_o, 1'b0);
      chk("rst_drop_no_pop", fifo_read_en_o, 1'b0);
    end
    txn(1'b1, 16'h000B, 64'h0000_0000_0000_0800, 16'h000B, 32'hC000_0099);
    wait_res("recover_res");
    chk("recover_evict", res_evict_o, 1'b1);
    wait_idle("recover_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
